// File: rtl/instr_cache_pkg.sv
// Shared types and field positions for the direct-mapped instruction cache.
// The 10-bit fetch address splits into word offset, line index and tag.
package instr_cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam int WORD_W       = 32;
    localparam int BLOCK_W      = 128;
    localparam int BLOCK_ADDR_W = 6;
    localparam int DEF_LINES    = 8;
    localparam int TAG_W        = BLOCK_ADDR_W - $clog2(DEF_LINES);

    localparam int WORD_LSB = 2;
    localparam int WORD_MSB = 3;
    localparam int IDX_LSB  = 4;
    localparam int ADDR_MSB = 9;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/instr_cache_array.sv
// Line storage for the instruction cache: valid bits, tags and block data.
// Valid bits clear synchronously; reads are combinational by index.
module instr_cache_array
    import instr_cache_pkg::*;
#(
    parameter int LINES = 8,
    parameter int IDX_W = 3,
    parameter int TW    = 3
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               we,
    input  logic [IDX_W-1:0]   windex,
    input  logic [TW-1:0]      wtag,
    input  logic [BLOCK_W-1:0] wdata,
    input  logic [IDX_W-1:0]   rindex,
    output logic [BLOCK_W-1:0] rdata,
    output logic [TW-1:0]      rtag,
    output logic               rvalid
);

    logic [LINES-1:0]   valid;
    logic [TW-1:0]      tags [LINES];
    logic [BLOCK_W-1:0] data [LINES];

    // Valid bits: cleared on reset, set when a refill lands.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= '0;
        end else if (we) begin
            valid[windex] <= 1'b1;
        end
    end

    // Tag and data payload need no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (we && !clear) begin
            tags[windex] <= wtag;
            data[windex] <= wdata;
        end
    end

    assign rdata  = data[rindex];
    assign rtag   = tags[rindex];
    assign rvalid = valid[rindex];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped instruction cache with a blocking single-block refill FSM.
// Optional hit/miss counters are built when INSTR_CACHE_STATS_EN is defined.
module instr_cache
    import instr_cache_pkg::*;
#(
    parameter int LINES = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [31:0]             PC,
    output logic [WORD_W-1:0]       INSTRUCTION,
    output logic                    BUSYWAIT,
    output logic                    MEM_READ,
    output logic [BLOCK_ADDR_W-1:0] MEM_ADDRESS,
    input  logic [BLOCK_W-1:0]      MEM_READDATA,
`ifdef INSTR_CACHE_STATS_EN
    input  logic                    MEM_BUSYWAIT,
    output logic [15:0]             HIT_COUNT,
    output logic [15:0]             MISS_COUNT
`else
    input  logic                    MEM_BUSYWAIT
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int LTW   = BLOCK_ADDR_W - IDX_W;

    state_t state;
    state_t nxt;

    logic [BLOCK_ADDR_W-1:0] pc_blk;
    logic [BLOCK_ADDR_W-1:0] miss_blk;
    logic [IDX_W-1:0]        pc_idx;
    logic [LTW-1:0]          pc_tag;
    logic [1:0]              pc_word;
    logic [BLOCK_W-1:0]      line;
    logic [LTW-1:0]          line_tag;
    logic                    line_valid;
    logic                    hit;
    logic                    we;
    logic                    unused_pc;

    assign pc_blk    = PC[ADDR_MSB:IDX_LSB];
    assign pc_idx    = pc_blk[IDX_W-1:0];
    assign pc_tag    = pc_blk[BLOCK_ADDR_W-1:IDX_W];
    assign pc_word   = PC[WORD_MSB:WORD_LSB];
    assign unused_pc = ^{PC[31:ADDR_MSB+1], PC[WORD_LSB-1:0]};

    assign hit         = line_valid && (line_tag == pc_tag);
    assign MEM_ADDRESS = miss_blk;

    instr_cache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TW    (LTW)
    ) u_array (
        .clk    (CLK),
        .clear  (RESET),
        .we     (we),
        .windex (miss_blk[IDX_W-1:0]),
        .wtag   (miss_blk[BLOCK_ADDR_W-1:IDX_W]),
        .wdata  (MEM_READDATA),
        .rindex (pc_idx),
        .rdata  (line),
        .rtag   (line_tag),
        .rvalid (line_valid)
    );

    // State register and miss-block latch.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            miss_blk <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && !hit) begin
                miss_blk <= pc_blk;
            end
        end
    end

    // Next state, CPU stall, memory request and refill write enable.
    always_comb begin
        nxt         = state;
        INSTRUCTION = '0;
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        we          = 1'b0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    INSTRUCTION = line[32'(pc_word) * WORD_W +: WORD_W];
                end else begin
                    BUSYWAIT = 1'b1;
                    nxt      = FETCH;
                end
            end
            FETCH: begin
                MEM_READ = 1'b1;
                BUSYWAIT = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    we  = 1'b1;
                    nxt = UPDATE;
                end
            end
            UPDATE: begin
                BUSYWAIT = 1'b1;
                nxt      = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (RESET) begin
            INSTRUCTION = '0;
            BUSYWAIT    = 1'b0;
            MEM_READ    = 1'b0;
            we          = 1'b0;
        end
    end

`ifdef INSTR_CACHE_STATS_EN
    // Saturating hit and miss counters sampled in IDLE.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else if (state == IDLE) begin
            if (hit && HIT_COUNT != CNT_MAX) begin
                HIT_COUNT <= HIT_COUNT + 16'd1;
            end
            if (!hit && MISS_COUNT != CNT_MAX) begin
                MISS_COUNT <= MISS_COUNT + 16'd1;
            end
        end
    end
`endif

endmodule
